// File: rtl/chunk_row_gen_if.sv
// Handshake/bus bundle for chunk_row_gen: a chunk-head request enters on the
// i_mofs side and row requests leave on the o_addr side.
interface chunk_row_gen_if #(
  parameter int WBW     = 16,
  parameter int DIM     = 4,
  parameter int N_ICFG  = 4,
  parameter int GBW     = 32,
  parameter int CNT_BW  = 8,
  localparam int ICFG_BW = $clog2(N_ICFG + 1)
);
  logic                          i_mofs_rdy;
  logic                          i_mofs_ack;
  logic [DIM-1:0][WBW-1:0]       i_mofs;
  logic [ICFG_BW-1:0]            i_id;
  logic                          o_addr_rdy;
  logic                          o_addr_ack;
  logic [GBW-1:0]                o_addr;
  logic [CNT_BW-1:0]             o_len;
  logic [ICFG_BW-1:0]            o_id;
  logic                          o_islast;

  modport master (
    output i_mofs_rdy, i_mofs, i_id, o_addr_ack,
    input  i_mofs_ack, o_addr_rdy, o_addr, o_len, o_id, o_islast
  );

  modport slave (
    input  i_mofs_rdy, i_mofs, i_id, o_addr_ack,
    output i_mofs_ack, o_addr_rdy, o_addr, o_len, o_id, o_islast
  );
endinterface

// File: rtl/chunk_row_gen.sv
// Turns one chunk origin into a burst of row requests: linearizes the
// per-dimension offset once, then steps the address by row_stride per row.
module chunk_row_gen #(
  parameter int WBW     = 16,
  parameter int DIM     = 4,
  parameter int N_ICFG  = 4,
  parameter int GBW     = 32,
  parameter int CNT_BW  = 8,
  localparam int ICFG_BW = $clog2(N_ICFG + 1)
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst,
  chunk_row_gen_if.slave                        bus,
  input  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0]   i_pitch,
  input  logic [N_ICFG-1:0][GBW-1:0]            i_base,
  input  logic [N_ICFG-1:0][CNT_BW-1:0]         i_nrow,
  input  logic [N_ICFG-1:0][CNT_BW-1:0]         i_row_len,
  input  logic [N_ICFG-1:0][GBW-1:0]            i_row_stride
);

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

  state_t                  state;
  logic [DIM-1:0][WBW-1:0] mofs_q;
  logic [ICFG_BW-1:0]      id_q;
  logic [CNT_BW-1:0]       r;
  logic [CNT_BW-1:0]       nrow_q;
  logic [GBW-1:0]          stride_q;

  logic [GBW-1:0]          addr_q;
  logic [CNT_BW-1:0]       len_q;
  logic [ICFG_BW-1:0]      oid_q;
  logic                    islast_q;
  logic                    addr_rdy_q;

  logic [DIM-1:0][GBW-1:0] sel_pitch;
  logic [GBW-1:0]          sel_base;
  logic [CNT_BW-1:0]       sel_nrow;
  logic [CNT_BW-1:0]       sel_row_len;
  logic [GBW-1:0]          sel_stride;
  logic [GBW-1:0]          calc_base;

  // An id with no matching configuration selects all-zero config, so
  // nrow=0 and the chunk is consumed without emitting rows.
  always_comb begin
    sel_pitch   = '0;
    sel_base    = '0;
    sel_nrow    = '0;
    sel_row_len = '0;
    sel_stride  = '0;
    for (int c = 0; c < N_ICFG; c++) begin
      if (id_q == ICFG_BW'(c)) begin
        sel_pitch   = i_pitch[c];
        sel_base    = i_base[c];
        sel_nrow    = i_nrow[c];
        sel_row_len = i_row_len[c];
        sel_stride  = i_row_stride[c];
      end
    end
  end

  // Offsets are sign-extended to GBW before the multiply; all sums wrap mod 2^GBW.
  always_comb begin
    calc_base = sel_base;
    for (int d = 0; d < DIM; d++)
      calc_base = calc_base + GBW'($signed(mofs_q[d])) * sel_pitch[d];
  end

  assign bus.i_mofs_ack = bus.i_mofs_rdy && (state == IDLE) && !i_rst;
  assign bus.o_addr_rdy = addr_rdy_q;
  assign bus.o_addr     = addr_q;
  assign bus.o_len      = len_q;
  assign bus.o_id       = oid_q;
  assign bus.o_islast   = islast_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      r          <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      oid_q      <= '0;
      islast_q   <= 1'b0;
      addr_rdy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_mofs_ack) begin
            mofs_q <= bus.i_mofs;
            id_q   <= bus.i_id;
            state  <= CALC;
          end
        end
        CALC: begin
          nrow_q   <= sel_nrow;
          stride_q <= sel_stride;
          r        <= '0;
          if (sel_nrow != '0) begin
            addr_q     <= calc_base;
            len_q      <= sel_row_len;
            oid_q      <= id_q;
            islast_q   <= (sel_nrow == CNT_BW'(1));
            addr_rdy_q <= 1'b1;
            state      <= EMIT;
          end else begin
            state <= IDLE;
          end
        end
        EMIT: begin
          if (bus.o_addr_ack) begin
            if (islast_q) begin
              r          <= '0;
              islast_q   <= 1'b0;
              addr_rdy_q <= 1'b0;
              state      <= IDLE;
            end else begin
              r        <= r + CNT_BW'(1);
              addr_q   <= addr_q + stride_q;
              // next row is last when r+1 == nrow-1
              islast_q <= (r + CNT_BW'(2) == nrow_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_row_gen.sv
// Directed bench for chunk_row_gen: stimulus on the falling edge, outputs
// sampled there too, against hand-computed addresses.
module tb_chunk_row_gen;
  localparam int WBW = 16, DIM = 4, N_ICFG = 4, GBW = 32, CNT_BW = 8;

  logic i_clk = 1'b0;
  logic i_rst;
  logic [N_ICFG-1:0][DIM-1:0][GBW-1:0] i_pitch;
  logic [N_ICFG-1:0][GBW-1:0]          i_base;
  logic [N_ICFG-1:0][CNT_BW-1:0]       i_nrow;
  logic [N_ICFG-1:0][CNT_BW-1:0]       i_row_len;
  logic [N_ICFG-1:0][GBW-1:0]          i_row_stride;

  int checks = 0;
  int errors = 0;

  chunk_row_gen_if #(.WBW(WBW), .DIM(DIM), .N_ICFG(N_ICFG), .GBW(GBW), .CNT_BW(CNT_BW)) bus ();

  chunk_row_gen #(.WBW(WBW), .DIM(DIM), .N_ICFG(N_ICFG), .GBW(GBW), .CNT_BW(CNT_BW)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus.slave),
    .i_pitch(i_pitch), .i_base(i_base), .i_nrow(i_nrow),
    .i_row_len(i_row_len), .i_row_stride(i_row_stride)
  );

  always #5 i_clk = ~i_clk;

  // Presents a chunk head and waits (bounded) for it to be taken; returns on
  // the falling edge after the accepting edge, i.e. while the DUT is in CALC.
  task automatic send_chunk(input logic [2:0] id, input logic [15:0] m0, input logic [15:0] m1);
    int n = 0;
    bus.i_id = id;
    bus.i_mofs = '0;
    bus.i_mofs[0] = m0;
    bus.i_mofs[1] = m1;
    bus.i_mofs_rdy = 1'b1;
    #1;
    while (!bus.i_mofs_ack && n < 50) begin
      @(negedge i_clk); #1; n++;
    end
    checks++;
    if (bus.i_mofs_ack !== 1'b1) begin
      errors++; $display("FAIL send_ack got %b expected 1 (timeout)", bus.i_mofs_ack);
    end
    @(negedge i_clk);
    bus.i_mofs_rdy = 1'b0;
    checks++;
    if (bus.o_addr_rdy !== 1'b0) begin
      errors++; $display("FAIL calc_rdy got %b expected 0", bus.o_addr_rdy);
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    bus.i_mofs_rdy = 1'b1;
    bus.o_addr_ack = 1'b0;
    @(negedge i_clk); @(negedge i_clk); #1;
    checks++;
    if (bus.i_mofs_ack !== 1'b0) begin
      errors++; $display("FAIL rst_ack got %b expected 0", bus.i_mofs_ack);
    end
    checks++;
    if ({bus.o_addr_rdy, bus.o_addr, bus.o_len, bus.o_id, bus.o_islast} !== '0) begin
      errors++; $display("FAIL rst_outputs got rdy=%b addr=%h len=%h id=%h last=%b expected all 0",
                         bus.o_addr_rdy, bus.o_addr, bus.o_len, bus.o_id, bus.o_islast);
    end
    bus.i_mofs_rdy = 1'b0;
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_basic();
    logic [31:0] exp_addr [3] = '{32'h10C2, 32'h1102, 32'h1142};
    bus.o_addr_ack = 1'b1;
    send_chunk(3'd0, 16'd2, 16'd3);
    @(negedge i_clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_addr_rdy !== 1'b1 || bus.o_addr !== exp_addr[i] || bus.o_len !== 8'd8 ||
          bus.o_id !== 3'd0 || bus.o_islast !== (i == 2)) begin
        errors++; $display("FAIL basic_row%0d got rdy=%b addr=%h len=%0d id=%0d last=%b expected rdy=1 addr=%h len=8 id=0 last=%b",
                           i, bus.o_addr_rdy, bus.o_addr, bus.o_len, bus.o_id, bus.o_islast, exp_addr[i], i == 2);
      end
      // config change mid-chunk must not leak into the rows in flight
      if (i == 0) i_base[0] = 32'hDEAD_0000;
      @(negedge i_clk);
    end
    checks++;
    if (bus.o_addr_rdy !== 1'b0) begin
      errors++; $display("FAIL basic_done_rdy got %b expected 0", bus.o_addr_rdy);
    end
    i_base[0] = 32'h1000;
  endtask

  task automatic test_stall();
    bus.o_addr_ack = 1'b0;
    send_chunk(3'd0, 16'd2, 16'd3);
    @(negedge i_clk);
    bus.o_addr_ack = 1'b1;
    @(negedge i_clk);
    bus.o_addr_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.o_addr_rdy !== 1'b1 || bus.o_addr !== 32'h1102 || bus.o_islast !== 1'b0) begin
        errors++; $display("FAIL stall_hold%0d got rdy=%b addr=%h last=%b expected rdy=1 addr=00001102 last=0",
                           i, bus.o_addr_rdy, bus.o_addr, bus.o_islast);
      end
      @(negedge i_clk);
    end
    bus.o_addr_ack = 1'b1;
    @(negedge i_clk);
    checks++;
    if (bus.o_addr_rdy !== 1'b1 || bus.o_addr !== 32'h1142 || bus.o_islast !== 1'b1) begin
      errors++; $display("FAIL stall_last got rdy=%b addr=%h last=%b expected rdy=1 addr=00001142 last=1",
                         bus.o_addr_rdy, bus.o_addr, bus.o_islast);
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_addr_rdy !== 1'b0) begin
      errors++; $display("FAIL stall_done_rdy got %b expected 0", bus.o_addr_rdy);
    end
  endtask

  task automatic test_nrow_zero();
    int seen = 0;
    send_chunk(3'd2, 16'd1, 16'd1);
    @(negedge i_clk);
    // two cycles after accept: back in IDLE, so a new head would be acked
    bus.i_mofs_rdy = 1'b1;
    #1;
    checks++;
    if (bus.i_mofs_ack !== 1'b1) begin
      errors++; $display("FAIL nrow0_idle_ack got %b expected 1", bus.i_mofs_ack);
    end
    bus.i_mofs_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.o_addr_rdy) seen++;
      @(negedge i_clk);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL nrow0_rdy got %0d cycles with rdy expected 0", seen);
    end
  endtask

  task automatic test_wrap();
    send_chunk(3'd1, 16'hFFFF, 16'd0);
    @(negedge i_clk);
    checks++;
    if (bus.o_addr_rdy !== 1'b1 || bus.o_addr !== 32'h0000_000C || bus.o_islast !== 1'b1 || bus.o_len !== 8'd4) begin
      errors++; $display("FAIL neg_ofs got rdy=%b addr=%h last=%b len=%0d expected rdy=1 addr=0000000c last=1 len=4",
                         bus.o_addr_rdy, bus.o_addr, bus.o_islast, bus.o_len);
    end
    @(negedge i_clk);
    send_chunk(3'd3, 16'd0, 16'd0);
    @(negedge i_clk);
    checks++;
    if (bus.o_addr !== 32'hFFFF_FFF0 || bus.o_islast !== 1'b0 || bus.o_id !== 3'd3) begin
      errors++; $display("FAIL wrap_row0 got addr=%h last=%b id=%0d expected addr=fffffff0 last=0 id=3",
                         bus.o_addr, bus.o_islast, bus.o_id);
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_addr_rdy !== 1'b1 || bus.o_addr !== 32'h0 || bus.o_islast !== 1'b1) begin
      errors++; $display("FAIL wrap_row1 got rdy=%b addr=%h last=%b expected rdy=1 addr=00000000 last=1",
                         bus.o_addr_rdy, bus.o_addr, bus.o_islast);
    end
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    i_nrow[0] = 8'd4;
    bus.o_addr_ack = 1'b1;
    send_chunk(3'd0, 16'd2, 16'd3);
    @(negedge i_clk);
    @(negedge i_clk);
    checks++;
    if (bus.o_addr !== 32'h1102) begin
      errors++; $display("FAIL rstmid_row1 got addr=%h expected 00001102", bus.o_addr);
    end
    i_rst = 1'b1;
    bus.i_mofs_rdy = 1'b1;
    #1;
    checks++;
    if (bus.i_mofs_ack !== 1'b0) begin
      errors++; $display("FAIL rstmid_ack got %b expected 0", bus.i_mofs_ack);
    end
    @(negedge i_clk);
    checks++;
    if ({bus.o_addr_rdy, bus.o_addr, bus.o_len, bus.o_id, bus.o_islast} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got rdy=%b addr=%h len=%h id=%h last=%b expected all 0",
                         bus.o_addr_rdy, bus.o_addr, bus.o_len, bus.o_id, bus.o_islast);
    end
    i_rst = 1'b0;
    bus.i_mofs_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus.o_addr_rdy) seen++;
      @(negedge i_clk);
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rstmid_no_rows got %0d rdy cycles expected 0", seen);
    end
    i_nrow[0] = 8'd2;
    send_chunk(3'd0, 16'd2, 16'd3);
    @(negedge i_clk);
    checks++;
    if (bus.o_addr !== 32'h10C2 || bus.o_islast !== 1'b0) begin
      errors++; $display("FAIL rstmid_restart got addr=%h last=%b expected addr=000010c2 last=0", bus.o_addr, bus.o_islast);
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_addr !== 32'h1102 || bus.o_islast !== 1'b1) begin
      errors++; $display("FAIL rstmid_restart_last got addr=%h last=%b expected addr=00001102 last=1", bus.o_addr, bus.o_islast);
    end
    @(negedge i_clk);
  endtask

  task automatic test_back_to_back();
    logic       exp_ack [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    i_nrow[0] = 8'd2;
    bus.o_addr_ack = 1'b1;
    bus.i_id = 3'd0;
    bus.i_mofs = '0;
    bus.i_mofs[0] = 16'd2;
    bus.i_mofs[1] = 16'd3;
    bus.i_mofs_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) bus.i_mofs = '0;
      #1;
      checks++;
      if (bus.i_mofs_ack !== exp_ack[i]) begin
        errors++; $display("FAIL b2b_ack_cyc%0d got %b expected %b", i, bus.i_mofs_ack, exp_ack[i]);
      end
      @(negedge i_clk);
    end
    bus.i_mofs_rdy = 1'b0;
    @(negedge i_clk);
    checks++;
    if (bus.o_addr_rdy !== 1'b1 || bus.o_addr !== 32'h1000 || bus.o_islast !== 1'b0) begin
      errors++; $display("FAIL b2b_second_row0 got rdy=%b addr=%h last=%b expected rdy=1 addr=00001000 last=0",
                         bus.o_addr_rdy, bus.o_addr, bus.o_islast);
    end
    @(negedge i_clk);
    checks++;
    if (bus.o_addr !== 32'h1040 || bus.o_islast !== 1'b1) begin
      errors++; $display("FAIL b2b_second_row1 got addr=%h last=%b expected addr=00001040 last=1", bus.o_addr, bus.o_islast);
    end
    @(negedge i_clk);
  endtask

  initial begin
    i_rst = 1'b1;
    bus.i_mofs_rdy = 1'b0;
    bus.i_mofs = '0;
    bus.i_id = '0;
    bus.o_addr_ack = 1'b0;
    i_pitch = '0;
    i_base = '0;
    i_nrow = '0;
    i_row_len = '0;
    i_row_stride = '0;
    i_pitch[0][0] = 32'd1;
    i_pitch[0][1] = 32'd64;
    i_base[0] = 32'h1000;
    i_nrow[0] = 8'd3;
    i_row_len[0] = 8'd8;
    i_row_stride[0] = 32'd64;
    i_pitch[1][0] = 32'd4;
    i_base[1] = 32'h10;
    i_nrow[1] = 8'd1;
    i_row_len[1] = 8'd4;
    i_pitch[2][0] = 32'd1;
    i_base[2] = 32'h2000;
    i_nrow[2] = 8'd0;
    i_row_len[2] = 8'd5;
    i_base[3] = 32'hFFFF_FFF0;
    i_nrow[3] = 8'd2;
    i_row_len[3] = 8'd2;
    i_row_stride[3] = 32'h10;
    @(negedge i_clk);

    test_reset();
    test_basic();
    test_stall();
    test_nrow_zero();
    test_wrap();
    test_reset_mid();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunk_row_gen.md
CHUNK_ROW_GEN -- requirements
Module: chunk_row_gen

Interface
REQ-001 SHALL have parameter WBW, default 16, width of each per-dimension memory offset.
REQ-002 SHALL have parameter DIM, default 4, number of memory dimensions.
REQ-003 SHALL have parameter N_ICFG, default 4, number of input configurations; ICFG_BW = clog2(N_ICFG+1).
REQ-004 SHALL have parameter GBW, default 32, global linear address width.
REQ-005 SHALL have parameter CNT_BW, default 8, row count / row length width.
REQ-006 SHALL have port i_clk  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port i_rst  input  1  synchronous reset, active-high.
REQ-008 SHALL have ports i_mofs_rdy input 1 / i_mofs_ack output 1  chunk-head handshake.
REQ-009 SHALL have port i_mofs  input  WBW x DIM  per-dimension chunk origin, two's complement.
REQ-010 SHALL have port i_id  input  ICFG_BW  configuration index for this chunk.
REQ-011 SHALL have port i_pitch  input  GBW x N_ICFG x DIM  linearization pitch per dimension.
REQ-012 SHALL have port i_base  input  GBW x N_ICFG  array base address.
REQ-013 SHALL have ports i_nrow, i_row_len  input  CNT_BW x N_ICFG  rows per chunk, words per row.
REQ-014 SHALL have port i_row_stride  input  GBW x N_ICFG  address step between rows.
REQ-015 SHALL have ports o_addr_rdy output 1 / o_addr_ack input 1  row-request handshake.
REQ-016 SHALL have ports o_addr GBW, o_len CNT_BW, o_id ICFG_BW, o_islast 1, all outputs.

Function
REQ-017 SHALL transfer on any handshake only in a cycle where rdy and ack are both high.
REQ-018 SHALL use a 3-state FSM: IDLE, CALC, EMIT.
REQ-019 SHALL assert i_mofs_ack combinationally = i_mofs_rdy && state==IDLE; no acceptance in CALC or EMIT.
REQ-020 SHALL on input accept register i_mofs and i_id and move IDLE->CALC.
REQ-021 SHALL in CALC register base = i_base[id] + sum over d of sext(mofs[d]) * i_pitch[id][d], modulo 2^GBW, and latch nrow, row_len, row_stride for id.
REQ-022 SHALL move CALC->EMIT if latched nrow != 0, else CALC->IDLE with no output transfer.
REQ-023 SHALL hold o_addr_rdy high in EMIT only; first o_addr_rdy two cycles after input accept.
REQ-024 SHALL drive o_addr = base + r*row_stride (mod 2^GBW), r = row counter starting 0; o_len = latched row_len; o_id = latched id.
REQ-025 SHALL drive o_islast = (r == nrow-1) while in EMIT, else 0.
REQ-026 SHALL on each output transfer increment r and add row_stride to o_addr; on transfer with o_islast go EMIT->IDLE and clear r.
REQ-027 SHALL hold all outputs stable while o_addr_rdy is high and o_addr_ack low.
REQ-028 SHALL read config arrays only in CALC; config changes after CALC do not affect the chunk in flight.
REQ-029 SHALL wrap address arithmetic silently; no overflow flag.
REQ-030 SHALL accept a new chunk no earlier than the cycle after the last-row transfer (IDLE).

Reset
REQ-031 SHALL on i_rst high force state IDLE, r=0, o_addr=0, o_len=0, o_id=0, o_islast=0, o_addr_rdy=0, i_mofs_ack=0 next cycle, regardless of state.
REQ-032 SHALL discard any in-flight chunk on reset mid-EMIT; no further rows emitted.
REQ-033 SHALL hold i_mofs_ack low during any cycle i_rst is high.

Verification
REQ-034 SHALL pass: id0 base=0x1000, pitch={1,64,0,0}, mofs={2,3,0,0}, nrow=3, stride=64, len=8, ack always -> addrs 0x10C2,0x1102,0x1142, len 8, islast on third only, first rdy 2 cycles after accept.
REQ-035 SHALL pass: same chunk, o_addr_ack held low 5 cycles on row 1 -> o_addr 0x1102 stable, row counter frozen, no extra transfer.
REQ-036 SHALL pass: nrow=0 for id2 -> input acked, o_addr_rdy never asserts, module back in IDLE 2 cycles after accept.
REQ-037 SHALL pass: mofs[0]=-1 (0xFFFF), pitch[0]=4, base=0x10 -> first o_addr 0xC; base=0xFFFFFFF0, stride=0x10, nrow=2 -> second addr 0x0.
REQ-038 SHALL pass: i_rst pulsed during EMIT row 1 of 4 -> next cycle o_addr_rdy=0, all outputs 0, next accepted chunk starts at r=0.
REQ-039 SHALL pass: i_mofs_rdy held high back-to-back two chunks -> second ack only in IDLE after first chunk's last-row transfer.
